// File: rtl/uart_regs_pkg.sv
// Shared register map, field positions, response codes and FSM state types
// for the AXI-Lite UART register block.
package uart_regs_pkg;

  localparam logic [11:0] TX_DATA_OFS = 12'h000;
  localparam logic [11:0] RX_DATA_OFS = 12'h004;
  localparam logic [11:0] STATUS_OFS  = 12'h008;
  localparam logic [11:0] CTRL_OFS    = 12'h00C;

  // Word indexes compared against addr[11:2]
  localparam logic [9:0] TX_DATA_IDX = TX_DATA_OFS[11:2];
  localparam logic [9:0] RX_DATA_IDX = RX_DATA_OFS[11:2];
  localparam logic [9:0] STATUS_IDX  = STATUS_OFS[11:2];
  localparam logic [9:0] CTRL_IDX    = CTRL_OFS[11:2];

  localparam int unsigned ST_TX_FULL   = 0;
  localparam int unsigned ST_TX_EMPTY  = 1;
  localparam int unsigned ST_RX_FULL   = 2;
  localparam int unsigned ST_RX_EMPTY  = 3;
  localparam int unsigned ST_RX_OVR    = 4;
  localparam int unsigned ST_TX_OVF    = 5;
  localparam int unsigned ST_RX_COUNT  = 8;

  localparam int unsigned CTRL_TX_FLUSH  = 0;
  localparam int unsigned CTRL_RX_FLUSH  = 1;
  localparam int unsigned CTRL_IRQ_RX_EN = 2;
  localparam int unsigned CTRL_IRQ_TX_EN = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with naturally wrapping pointers; flush overrides push and pop,
// and a push into a full FIFO succeeds when a pop happens in the same cycle.
module uart_byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [7:0]                 din,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 head
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    full    = (cnt == CW'(DEPTH));
    empty   = (cnt == '0);
    count   = cnt;
    head    = mem[rd_ptr];
    do_pop  = pop && !empty && !flush;
    do_push = push && (!full || do_pop) && !flush;
  end

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/axi_uart_regs.sv
// AXI-Lite register slave bridging to UART TX/RX byte streams via two FIFOs.
// Optional interrupt output is enabled by defining UART_REGS_IRQ_EN.
module axi_uart_regs
  import uart_regs_pkg::*;
#(
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned RX_DEPTH = 16
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
`ifdef UART_REGS_IRQ_EN
  ,
  output logic        irq
`endif
);
  localparam int unsigned RX_CW = $clog2(RX_DEPTH) + 1;
  localparam int unsigned TX_CW = $clog2(TX_DEPTH) + 1;

  w_state_t w_state;
  r_state_t r_state;

  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic [TX_CW-1:0] tx_count;
  logic [RX_CW-1:0] rx_count;
  logic [7:0]       rx_head;
  logic             rx_ovr, tx_ovf;
  logic             irq_rx_en, irq_tx_en;

  logic        wr_en, rd_en;
  logic [9:0]  wr_idx, rd_idx;
  logic        tx_push, tx_pop, tx_flush;
  logic        rx_pop, rx_flush;
  logic        sts_wr, ctrl_wr;
  logic [1:0]  wr_resp;
  logic [31:0] rd_val;

  logic unused_ok;
  assign unused_ok = &{1'b0, wlast, awaddr[31:12], awaddr[1:0], araddr[31:12],
                       araddr[1:0], wdata[31:8], tx_count};

  assign tx_valid = !tx_empty;

  always_comb begin
    wr_en    = (w_state == W_IDLE) && awready && awvalid && wvalid;
    rd_en    = (r_state == R_IDLE) && arready && arvalid;
    wr_idx   = awaddr[11:2];
    rd_idx   = araddr[11:2];
    tx_pop   = tx_valid && tx_ready;
    tx_push  = wr_en && (wr_idx == TX_DATA_IDX);
    sts_wr   = wr_en && (wr_idx == STATUS_IDX);
    ctrl_wr  = wr_en && (wr_idx == CTRL_IDX);
    tx_flush = ctrl_wr && wdata[CTRL_TX_FLUSH];
    rx_flush = ctrl_wr && wdata[CTRL_RX_FLUSH];
    rx_pop   = rd_en && (rd_idx == RX_DATA_IDX) && !rx_empty;

    case (wr_idx)
      TX_DATA_IDX: wr_resp = (tx_full && !tx_pop) ? RESP_SLVERR : RESP_OKAY;
      STATUS_IDX:  wr_resp = RESP_OKAY;
      CTRL_IDX:    wr_resp = RESP_OKAY;
      default:     wr_resp = RESP_SLVERR;
    endcase

    rd_val = '0;
    case (rd_idx)
      RX_DATA_IDX: if (!rx_empty) rd_val = {23'b0, 1'b1, rx_head};
      STATUS_IDX: begin
        rd_val[ST_TX_FULL]              = tx_full;
        rd_val[ST_TX_EMPTY]             = tx_empty;
        rd_val[ST_RX_FULL]              = rx_full;
        rd_val[ST_RX_EMPTY]             = rx_empty;
        rd_val[ST_RX_OVR]               = rx_ovr;
        rd_val[ST_TX_OVF]               = tx_ovf;
        rd_val[ST_RX_COUNT +: 8]        = 8'(rx_count);
      end
      CTRL_IDX: begin
        rd_val[CTRL_IRQ_RX_EN] = irq_rx_en;
        rd_val[CTRL_IRQ_TX_EN] = irq_tx_en;
      end
      default: rd_val = '0;
    endcase
  end

  uart_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk    (aclk),
    .resetn (aresetn),
    .push   (tx_push),
    .din    (wdata[7:0]),
    .pop    (tx_pop),
    .flush  (tx_flush),
    .full   (tx_full),
    .empty  (tx_empty),
    .count  (tx_count),
    .head   (tx_data)
  );

  uart_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk    (aclk),
    .resetn (aresetn),
    .push   (rx_valid),
    .din    (rx_data),
    .pop    (rx_pop),
    .flush  (rx_flush),
    .full   (rx_full),
    .empty  (rx_empty),
    .count  (rx_count),
    .head   (rx_head)
  );

  // Write channel: awready/wready pulse one cycle, the handshake cycle applies the write
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (wr_en) begin
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= wr_resp;
            w_state <= W_RESP;
          end else if (awvalid && wvalid) begin
            awready <= 1'b1;
            wready  <= 1'b1;
          end else begin
            awready <= 1'b0;
            wready  <= 1'b0;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rdata   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (rd_en) begin
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rlast   <= 1'b1;
            rdata   <= rd_val;
            r_state <= R_DATA;
          end else begin
            arready <= arvalid;
          end
        end
        R_DATA: begin
          if (rready) begin
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Sticky flags: a same-cycle set wins over a write-1-to-clear
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rx_ovr <= 1'b0;
      tx_ovf <= 1'b0;
    end else begin
      if ((sts_wr && wdata[ST_RX_OVR]) && !(rx_valid && rx_full && !rx_pop && !rx_flush))
        rx_ovr <= 1'b0;
      else if (rx_valid && rx_full && !rx_pop && !rx_flush)
        rx_ovr <= 1'b1;
      if ((sts_wr && wdata[ST_TX_OVF]) && !(tx_push && tx_full && !tx_pop))
        tx_ovf <= 1'b0;
      else if (tx_push && tx_full && !tx_pop)
        tx_ovf <= 1'b1;
    end
  end

`ifdef UART_REGS_IRQ_EN
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      irq_rx_en <= 1'b0;
      irq_tx_en <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        irq_rx_en <= wdata[CTRL_IRQ_RX_EN];
        irq_tx_en <= wdata[CTRL_IRQ_TX_EN];
      end
      irq <= (irq_rx_en && !rx_empty) || (irq_tx_en && tx_empty) || rx_ovr;
    end
  end
`else
  assign irq_rx_en = 1'b0;
  assign irq_tx_en = 1'b0;
`endif

endmodule

// File: tb/tb_axi_uart_regs.sv
// Directed self-checking bench for axi_uart_regs (default build, 16-deep FIFOs).
module tb_axi_uart_regs;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic        wlast = 1'b1;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axi_uart_regs #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid)
  );

  // Bus helpers: called and returning at a negedge
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, output logic [1:0] resp);
    int unsigned n;
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while (!awready && n < 20) begin @(negedge aclk); n++; end
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    while (!bvalid && n < 40) begin @(negedge aclk); n++; end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL write_timeout addr=%h got n=%0d required <20", a, n);
    end
    resp = bresp;
    @(negedge aclk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
    int unsigned n;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(negedge aclk); n++; end
    @(negedge aclk);
    arvalid = 1'b0;
    while (!rvalid && n < 40) begin @(negedge aclk); n++; end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL read_timeout addr=%h got n=%0d required <20", a, n);
    end
    d = rdata;
    @(negedge aclk);
    rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    checks++;
    if ({awready, wready, bvalid, arready, rvalid, rlast, tx_valid, bresp, rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b_%h required 0", {awready, wready, bvalid, arready, rvalid, rlast, tx_valid, bresp}, rdata);
    end
    aresetn = 1'b1;
    @(negedge aclk);
    axi_read(32'h008, d);
    checks++;
    if (d !== 32'h0000_000A) begin errors++; $display("FAIL reset_status got %h required 0000000a", d); end
  endtask

  task automatic test_tx_write();
    logic [1:0] r;
    tx_ready = 1'b0;
    axi_write(32'h000, 32'h41, r);
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL tx_write_resp got %b required 00", r); end
    checks++;
    if ({tx_valid, tx_data} !== 9'h141) begin errors++; $display("FAIL tx_head got %b/%h required 1/41", tx_valid, tx_data); end
    tx_ready = 1'b1;
    @(negedge aclk);
    tx_ready = 1'b0;
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_pop got tx_valid=%b required 0", tx_valid); end
  endtask

  task automatic test_tx_overflow();
    logic [1:0]  r;
    logic [31:0] d;
    int bad;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      axi_write(32'h000, 32'(i), r);
      if (r !== 2'b00) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL tx_fill_resp got %0d errors required 0", bad); end
    axi_write(32'h000, 32'hEE, r);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL tx_ovf_resp got %b required 10", r); end
    axi_read(32'h008, d);
    checks++;
    if (d !== 32'h0000_0029) begin errors++; $display("FAIL tx_ovf_status got %h required 00000029", d); end
    checks++;
    if (tx_data !== 8'h00) begin errors++; $display("FAIL tx_full_head got %h required 00", tx_data); end
    axi_write(32'h008, 32'h20, r);
    axi_read(32'h00B, d);
    checks++;
    if (d !== 32'h0000_0009) begin errors++; $display("FAIL tx_ovf_clear got %h required 00000009", d); end
    axi_write(32'h00C, 32'h1, r);
    axi_read(32'h008, d);
    checks++;
    if (d !== 32'h0000_000A || tx_valid !== 1'b0) begin
      errors++; $display("FAIL tx_flush got %h/%b required 0000000a/0", d, tx_valid);
    end
  endtask

  task automatic test_rx();
    logic [31:0] d;
    rx_data = 8'h5A; rx_valid = 1'b1;
    @(negedge aclk);
    rx_valid = 1'b0;
    axi_read(32'h008, d);
    checks++;
    if (d !== 32'h0000_0102) begin errors++; $display("FAIL rx_status got %h required 00000102", d); end
    axi_read(32'h004, d);
    checks++;
    if (d !== 32'h0000_015A) begin errors++; $display("FAIL rx_read got %h required 0000015a", d); end
    axi_read(32'h004, d);
    checks++;
    if (d !== 32'h0000_0000) begin errors++; $display("FAIL rx_read_empty got %h required 00000000", d); end
  endtask

  task automatic test_rx_full_pop();
    logic [31:0] d;
    logic [1:0]  r;
    int unsigned n;
    for (int i = 0; i < 16; i++) begin
      rx_data = 8'(8'h10 + i); rx_valid = 1'b1;
      @(negedge aclk);
    end
    rx_valid = 1'b0;
    axi_read(32'h008, d);
    checks++;
    if (d !== 32'h0000_1006) begin errors++; $display("FAIL rx_full_status got %h required 00001006", d); end
    araddr = 32'h004; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(negedge aclk); n++; end
    rx_data = 8'h99; rx_valid = 1'b1;
    @(negedge aclk);
    rx_valid = 1'b0; arvalid = 1'b0;
    while (!rvalid && n < 40) begin @(negedge aclk); n++; end
    d = rdata;
    @(negedge aclk);
    rready = 1'b0;
    checks++;
    if (d !== 32'h0000_0110) begin errors++; $display("FAIL rx_simul_data got %h required 00000110", d); end
    axi_read(32'h008, d);
    checks++;
    if (d !== 32'h0000_1006) begin errors++; $display("FAIL rx_simul_status got %h required 00001006", d); end
    rx_data = 8'h77; rx_valid = 1'b1;
    @(negedge aclk);
    rx_valid = 1'b0;
    axi_read(32'h008, d);
    checks++;
    if (d !== 32'h0000_1016) begin errors++; $display("FAIL rx_ovr_status got %h required 00001016", d); end
    axi_read(32'h004, d);
    checks++;
    if (d !== 32'h0000_0111) begin errors++; $display("FAIL rx_order got %h required 00000111", d); end
    axi_write(32'h008, 32'h10, r);
    axi_write(32'h00C, 32'h2, r);
    axi_read(32'h008, d);
    checks++;
    if (d !== 32'h0000_000A) begin errors++; $display("FAIL rx_clear_flush got %h required 0000000a", d); end
  endtask

  task automatic test_unmapped();
    logic [1:0]  r;
    logic [31:0] d;
    axi_write(32'h010, 32'hFF, r);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL unmapped_write got %b required 10", r); end
    axi_write(32'h004, 32'h12, r);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL rxdata_write got %b required 10", r); end
    axi_read(32'h010, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h required 00000000", d); end
    axi_write(32'h00C, 32'hF, r);
    axi_read(32'h00C, d);
    checks++;
    if (d !== 32'h0 || r !== 2'b00) begin errors++; $display("FAIL ctrl_read got %h/%b required 00000000/00", d, r); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [1:0]  r;
    int unsigned n;
    int bad;
    tx_ready = 1'b0;
    awaddr = 32'h000; wdata = 32'h33; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    while (!awready && n < 20) begin @(negedge aclk); n++; end
    @(negedge aclk);
    wdata = 32'h44;
    axi_read(32'h008, d);
    checks++;
    if (d !== 32'h0000_0008) begin errors++; $display("FAIL b2b_status got %h required 00000008", d); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (bvalid !== 1'b1 || awready !== 1'b0) bad++;
      @(negedge aclk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL b2b_hold got %0d bad cycles required 0", bad); end
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL b2b_bdone got bvalid=%b required 0", bvalid); end
    while (!awready && n < 40) begin @(negedge aclk); n++; end
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    while (!bvalid && n < 60) begin @(negedge aclk); n++; end
    r = bresp;
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    checks++;
    if (r !== 2'b00 || n >= 40) begin errors++; $display("FAIL b2b_second got resp=%b n=%0d required 00 n<40", r, n); end
    checks++;
    if ({tx_valid, tx_data} !== 9'h133) begin errors++; $display("FAIL b2b_head0 got %b/%h required 1/33", tx_valid, tx_data); end
    tx_ready = 1'b1;
    @(negedge aclk);
    tx_ready = 1'b0;
    checks++;
    if ({tx_valid, tx_data} !== 9'h144) begin errors++; $display("FAIL b2b_head1 got %b/%h required 1/44", tx_valid, tx_data); end
  endtask

  task automatic test_reset_mid();
    awaddr = 32'h000; wdata = 32'h55; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h008; arvalid = 1'b1;
    @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge aclk);
    checks++;
    if ({awready, wready, bvalid, arready, rvalid, rlast, tx_valid, bresp, rdata} !== '0) begin
      errors++;
      $display("FAIL reset_mid got %b_%h required 0", {awready, wready, bvalid, arready, rvalid, rlast, tx_valid, bresp}, rdata);
    end
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  initial begin
    test_reset();
    test_tx_write();
    test_tx_overflow();
    test_rx();
    test_rx_full_pop();
    test_unmapped();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
